// File: rtl/maxpool_pkg.sv
// Shared types and helpers for the 1-D max-pooling stage.
package maxpool_pkg;
   localparam int T_DEF = 16;

   typedef logic signed [T_DEF-1:0] sample_t;

   typedef struct packed {
      sample_t data;
      logic    last;
   } out_entry_t;

   function automatic int n_out(input int n_in, input int pool);
      return (n_in + pool - 1) / pool;
   endfunction
endpackage

// File: rtl/stream_fifo2.sv
// Two-entry registered first-word-fall-through FIFO; head entry is presented
// directly on pop_data and reads as zero while empty.
module stream_fifo2 #(
   parameter int W = 17
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] push_data,
   input  logic         push,
   output logic         full,
   input  logic         pop,
   output logic         empty,
   output logic [W-1:0] pop_data
);
   logic [W-1:0] head, tail;
   logic [1:0]   count;
   logic         do_push, do_pop;

   assign full     = (count == 2'd2);
   assign empty    = (count == 2'd0);
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign pop_data = empty ? '0 : head;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= 2'd0;
         head  <= '0;
         tail  <= '0;
      end else begin
         case ({do_push, do_pop})
            2'b10: begin
               if (count == 2'd0) head <= push_data;
               else               tail <= push_data;
               count <= count + 2'd1;
            end
            2'b01: begin
               head  <= tail;
               count <= count - 2'd1;
            end
            // push is gated by full, so a simultaneous push/pop only happens at count 1
            2'b11: head <= push_data;
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/maxpool_stream.sv
// Streaming 1-D max pool: non-overlapping windows of POOL samples per N_IN-sample
// frame, signed max per window, frame-end marker on the last output.
module maxpool_stream
   import maxpool_pkg::*;
#(
   parameter int T    = T_DEF,
   parameter int N_IN = 32,
   parameter int POOL = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [T-1:0] s_data_in_y,
   input  logic         s_valid_y,
   output logic         s_ready_y,
   output logic [T-1:0] m_data_out_z,
   output logic         m_valid_z,
   input  logic         m_ready_z,
   output logic         m_last_z
);
   localparam int WW = (POOL > 1) ? $clog2(POOL) : 1;
   localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;

   logic [WW-1:0]       win_cnt;
   logic [IW-1:0]       in_cnt;
   logic signed [T-1:0] max_r, x, cand;
   logic                in_beat, win_end, frame_end, close;
   logic                fifo_full, fifo_empty;
   logic [T:0]          fifo_out;

   assign x         = s_data_in_y;
   assign in_beat   = s_valid_y & s_ready_y;
   assign win_end   = (win_cnt == WW'(POOL - 1));
   assign frame_end = (in_cnt == IW'(N_IN - 1));
   assign close     = in_beat & (win_end | frame_end);
   assign cand      = (win_cnt == '0) ? x : ((x > max_r) ? x : max_r);

   // Ready only looks at FIFO occupancy, so downstream ready never reaches upstream.
   assign s_ready_y = ~reset & ~fifo_full;

   always_ff @(posedge clk) begin
      if (reset) begin
         win_cnt <= '0;
         in_cnt  <= '0;
         max_r   <= '0;
      end else if (in_beat) begin
         max_r   <= cand;
         win_cnt <= (win_end | frame_end) ? '0 : win_cnt + 1'b1;
         in_cnt  <= frame_end ? '0 : in_cnt + 1'b1;
      end
   end

   stream_fifo2 #(.W(T + 1)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push_data ({cand, frame_end}),
      .push      (close),
      .full      (fifo_full),
      .pop       (m_valid_z & m_ready_z),
      .empty     (fifo_empty),
      .pop_data  (fifo_out)
   );

   assign m_valid_z    = ~fifo_empty;
   assign m_data_out_z = fifo_out[T:1];
   assign m_last_z     = fifo_out[0];
endmodule
